nn_mul_share_arb: RTL

//  Shares one unsigned 9x12->19 multiplier among NUM_REQ requesters in the AlexNet datapath.

---
 rtl/nn_mul_share_arb.sv | 139 +++++++++++++
 1 files changed

// File: rtl/nn_mul_share_arb.sv
// Shared unsigned A x B multiplier for NUM_REQ requesters.
// A round-robin arbiter accepts at most one request per cycle. The operands
// pass through two registered stages (operands, then product), and the product
// is returned on a shared bus. A one-hot rsp_valid tags which requester owns
// the product, and each requester can apply its own backpressure.
module nn_mul_share_arb #(
  parameter int NUM_REQ  = 4,
  parameter int A_WIDTH  = 9,
  parameter int B_WIDTH  = 12,
  parameter int P_WIDTH  = 19,
  parameter int ID_WIDTH = 2
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]           rsp_valid,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic [P_WIDTH-1:0]           rsp_prod,
  output logic                         busy
);

  localparam int F_WIDTH = A_WIDTH + B_WIDTH;

  // Round-robin pointer: the requester with the highest priority on the next scan.
  logic [ID_WIDTH-1:0] rr_ptr;

  // Stage 1: the operand register.
  logic                s1_vld;
  logic [ID_WIDTH-1:0] s1_id;
  logic [A_WIDTH-1:0]  s1_a;
  logic [B_WIDTH-1:0]  s1_b;

  // Stage 2: the product register, which drives the response bus.
  logic                s2_vld;
  logic [ID_WIDTH-1:0] s2_id;
  logic [P_WIDTH-1:0]  s2_prod;

  logic                grant_found;
  logic [ID_WIDTH-1:0] grant_idx;
  logic                stall2;
  logic                adv;
  logic                accept_ok;
  logic                accept;
  logic [A_WIDTH-1:0]  sel_a;
  logic [B_WIDTH-1:0]  sel_b;
  logic [F_WIDTH-1:0]  full_prod;

  // Stage 2 stalls only when its owner refuses the response. Stage 1 may load
  // when it is empty or when its contents move into stage 2 on this edge.
  assign stall2    = s2_vld & ~rsp_ready[s2_id];
  assign adv       = ~stall2;
  assign accept_ok = ~s1_vld | adv;

  // Round-robin scan: first try indices at or above rr_ptr, then wrap to the
  // indices below it.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch. Otherwise a path that leaves it unassigned would infer a latch.
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && req_valid[i] && (ID_WIDTH'(i) >= rr_ptr)) begin
        grant_found = 1'b1;
        grant_idx   = ID_WIDTH'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && req_valid[i]) begin
        grant_found = 1'b1;
        grant_idx   = ID_WIDTH'(i);
      end
    end
  end

  // Hold the handshake low while reset is asserted. This keeps a requester
  // from believing it was accepted by a block that is being flushed.
  assign accept    = grant_found & accept_ok & ap_rst_n;
  assign req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;

  assign sel_a = req_a[grant_idx*A_WIDTH +: A_WIDTH];
  assign sel_b = req_b[grant_idx*B_WIDTH +: B_WIDTH];

  // Zero-extend both operands to the full product width. Stage 2 then keeps
  // only the low P_WIDTH bits, with no saturation.
  assign full_prod = {{B_WIDTH{1'b0}}, s1_a} * {{A_WIDTH{1'b0}}, s1_b};

  // The pointer advances past the requester that was just accepted.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rr_ptr <= '0;
    end else if (accept) begin
      // NOTE: sequential state is always updated with non-blocking
      // assignments, so every register samples its pre-edge inputs.
      rr_ptr <= (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + ID_WIDTH'(1);
    end
  end

  // Stage 1 captures the granted operands. It empties when it advances with
  // no new request, and holds while stage 2 is stalled.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      // NOTE: the data registers are cleared along with the valid bits, so the
      // response bus reads zero after reset instead of stale operands.
      s1_vld <= 1'b0;
      s1_id  <= '0;
      s1_a   <= '0;
      s1_b   <= '0;
    end else if (accept) begin
      s1_vld <= 1'b1;
      s1_id  <= grant_idx;
      s1_a   <= sel_a;
      s1_b   <= sel_b;
    end else if (adv) begin
      s1_vld <= 1'b0;
    end
  end

  // Stage 2 takes the truncated product whenever it is not stalled. It can
  // retire and refill on the same edge, so back-to-back results leave no bubble.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s2_vld  <= 1'b0;
      s2_id   <= '0;
      s2_prod <= '0;
    end else if (adv) begin
      s2_vld  <= s1_vld;
      s2_id   <= s1_id;
      s2_prod <= full_prod[P_WIDTH-1:0];
    end
  end

  assign rsp_valid = s2_vld ? (NUM_REQ'(1) << s2_id) : '0;
  assign rsp_prod  = s2_prod;
  assign busy      = s1_vld | s2_vld;

endmodule
